// File: rtl/triangle_scheduler.sv
// Frame sequencer: fetches each triangle from mesh BRAM, runs it through the projector and
// forwards accepted results to the rasterizer. Optional watchdog: TRI_SCHED_WATCHDOG_EN.
module triangle_scheduler #(
  parameter int COORD_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start,
  input  logic [ADDR_WIDTH-1:0]    tri_count,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [9*COORD_WIDTH-1:0] mem_data,
  output logic                     proj_start,
  output logic [9*COORD_WIDTH-1:0] proj_verts,
  input  logic                     proj_busy,
  input  logic                     proj_done,
  input  logic                     proj_valid,
  input  logic [1:0]               proj_status,
  input  logic [9*COORD_WIDTH-1:0] proj_result,
  output logic [9*COORD_WIDTH-1:0] out_verts,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic [ADDR_WIDTH-1:0]    emitted_count,
  output logic [ADDR_WIDTH-1:0]    culled_count
`ifdef TRI_SCHED_WATCHDOG_EN
  ,
  output logic                     wdog_flag
`endif
);

`ifdef TRI_SCHED_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_EMIT, S_NEXT, S_FINISH
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] tri_total;
  logic [31:0]           wait_cnt;
  logic                  fetch_hit, launch_ok, done_seen, accept, timeout, last_tri;

  assign mem_addr  = idx;
  assign last_tri  = (idx == tri_total - ADDR_WIDTH'(1));
  assign fetch_hit = (state == S_FETCH) && (wait_cnt == 32'(MEM_LATENCY));
  assign launch_ok = (state == S_LAUNCH) && !proj_busy && !proj_done;
  // The launch cycle and the one after it may still show the previous triangle's done.
  assign done_seen = (state == S_WAIT) && proj_done && (wait_cnt >= 32'd2);
  assign accept    = done_seen && proj_valid && (proj_status == 2'd0);
  assign timeout   = WDOG_ON && (state == S_WAIT) && !done_seen &&
                     (wait_cnt >= 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (frame_start) state_next = (tri_count == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  if (fetch_hit) state_next = S_LAUNCH;
      S_LAUNCH: if (launch_ok) state_next = S_WAIT;
      S_WAIT: begin
        if (accept)                    state_next = S_EMIT;
        else if (done_seen || timeout) state_next = S_NEXT;
      end
      S_EMIT:   if (out_valid && out_ready) state_next = S_NEXT;
      S_NEXT:   state_next = last_tri ? S_FINISH : S_FETCH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx           <= '0;
      tri_total     <= '0;
      wait_cnt      <= '0;
      proj_start    <= 1'b0;
      proj_verts    <= '0;
      out_verts     <= '0;
      out_valid     <= 1'b0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      emitted_count <= '0;
      culled_count  <= '0;
`ifdef TRI_SCHED_WATCHDOG_EN
      wdog_flag     <= 1'b0;
`endif
    end else begin
      proj_start <= 1'b0;
      frame_done <= 1'b0;
      // Per-state cycle counter, restarted on every state change and saturating.
      if (state_next != state)  wait_cnt <= '0;
      else if (wait_cnt != '1)  wait_cnt <= wait_cnt + 32'd1;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            tri_total     <= tri_count;
            idx           <= '0;
            emitted_count <= '0;
            culled_count  <= '0;
            frame_busy    <= 1'b1;
`ifdef TRI_SCHED_WATCHDOG_EN
            wdog_flag     <= 1'b0;
`endif
          end
        end
        S_FETCH:  if (fetch_hit) proj_verts <= mem_data;
        S_LAUNCH: if (launch_ok) proj_start <= 1'b1;
        S_WAIT: begin
          if (accept) begin
            out_verts <= proj_result;
            out_valid <= 1'b1;
          end else if (done_seen || timeout) begin
            culled_count <= culled_count + ADDR_WIDTH'(1);
`ifdef TRI_SCHED_WATCHDOG_EN
            if (timeout) wdog_flag <= 1'b1;
`endif
          end
        end
        S_EMIT: begin
          if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
            emitted_count <= emitted_count + ADDR_WIDTH'(1);
          end
        end
        S_NEXT:   if (!last_tri) idx <= idx + ADDR_WIDTH'(1);
        S_FINISH: begin
          frame_done <= 1'b1;
          frame_busy <= 1'b0;
          idx        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_scheduler.sv
// Randomized bench for triangle_scheduler with BRAM/projector models and a transaction-level
// reference: expected beats are the projected data of every triangle whose code is "ok".
module tb_triangle_scheduler;
  localparam int CW = 32;
  localparam int AW = 12;
  localparam int ML = 2;
  localparam int VW = 9 * CW;

  logic          clk_in, rst_in, frame_start;
  logic [AW-1:0] tri_count, mem_addr, emitted_count, culled_count;
  logic [VW-1:0] mem_data, proj_verts, proj_result, out_verts;
  logic          proj_start, proj_busy, proj_done, proj_valid, out_valid, out_ready;
  logic [1:0]    proj_status;
  logic          frame_busy, frame_done;
`ifdef TRI_SCHED_WATCHDOG_EN
  logic          wdog_flag;
`endif

  triangle_scheduler #(.COORD_WIDTH(CW), .ADDR_WIDTH(AW), .MEM_LATENCY(ML), .WDOG_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start), .tri_count(tri_count),
    .mem_addr(mem_addr), .mem_data(mem_data), .proj_start(proj_start), .proj_verts(proj_verts),
    .proj_busy(proj_busy), .proj_done(proj_done), .proj_valid(proj_valid),
    .proj_status(proj_status), .proj_result(proj_result), .out_verts(out_verts),
    .out_valid(out_valid), .out_ready(out_ready), .frame_busy(frame_busy),
    .frame_done(frame_done), .emitted_count(emitted_count), .culled_count(culled_count)
`ifdef TRI_SCHED_WATCHDOG_EN
    , .wdog_flag(wdog_flag)
`endif
  );

  int n_vec, n_err;
  int starts, starts0, beats, mdl_e, mdl_c;
  int stall_beat, stall_len, stall_cnt;
  bit rnd_ready, hang;
  int fixed_codes [4];
  logic [VW-1:0] mem [0:63];
  logic [VW-1:0] exp_q [$];
  logic [5:0]    hist [ML];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM model: data for the address presented ML cycles earlier.
  always @(negedge clk_in) begin
    mem_data = mem[hist[ML-1]];
    for (int i = ML - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = mem_addr[5:0];
  end

  // Projector model: code in the two low data bits selects the outcome (3 = not valid).
  logic [VW-1:0] held;
  logic [1:0]    pcode;
  int            lat, done_left;
  always @(negedge clk_in) begin
    if (rst_in) begin
      proj_busy = 0; proj_done = 0; proj_valid = 0; proj_status = 0; proj_result = '0;
      lat = 0; done_left = 0;
    end else begin
      proj_done = 0; proj_valid = 0;
      if (proj_busy) check_v("proj_verts_stable", proj_verts, held);
      if (proj_start) begin
        starts++;
        check_i("start_while_busy", int'(proj_busy || done_left != 0), 0);
        held = proj_verts; proj_busy = 1; lat = $urandom_range(1, 6);
      end else if (proj_busy && !hang) begin
        if (lat > 0) lat--;
        else begin
          proj_busy = 0; done_left = $urandom_range(1, 3); pcode = held[1:0];
        end
      end
      if (done_left > 0) begin
        proj_done = 1; proj_valid = (pcode != 2'd3);
        proj_status = (pcode == 2'd3) ? 2'd0 : pcode;
        proj_result = ~held; done_left--;
      end
    end
  end

  // Output side: drive ready, then score every completed beat and every held beat.
  bit            hold_pend;
  logic [VW-1:0] hold_v;
  always @(negedge clk_in) begin
    if (rst_in) begin
      out_ready = 1'b1; hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check_i("hold_valid", int'(out_valid), 1);
        check_v("hold_verts", out_verts, hold_v);
      end
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && beats == stall_beat && stall_cnt < stall_len) begin
        out_ready = 1'b0; stall_cnt++;
      end
      if (out_valid) check_i("start_during_emit", int'(proj_start), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: got %h expected none", out_verts);
        end else check_v("beat", out_verts, exp_q.pop_front());
        beats++;
        hold_pend = 0;
      end else begin
        hold_pend = out_valid; hold_v = out_verts;
      end
    end
  end

  // mode 0: all ok, 1: fixed_codes, 2: random codes
  task automatic start_frame(input int n, input int mode);
    int code;
    mdl_e = 0; mdl_c = 0;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 9; w++) mem[i][w*CW +: CW] = $urandom;
      code = (mode == 0) ? 0 : (mode == 1) ? fixed_codes[i] : $urandom_range(0, 3);
      mem[i][1:0] = 2'(code);
      if (code == 0) begin exp_q.push_back(~mem[i]); mdl_e++; end
      else mdl_c++;
    end
    starts0 = starts; beats = 0;
    tri_count = AW'(n); frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
  endtask

  task automatic end_frame(input string name, input int exp_e, input int exp_c, input int exp_s);
    int c = 0;
    while (!frame_done && c < 5000) begin @(negedge clk_in); c++; end
    check_i({name, " frame_done"}, int'(frame_done), 1);
    check_i({name, " emitted"}, int'(emitted_count), exp_e);
    check_i({name, " culled"}, int'(culled_count), exp_c);
    check_i({name, " leftover"}, exp_q.size(), 0);
    check_i({name, " starts"}, starts - starts0, exp_s);
    check_i({name, " busy"}, int'(frame_busy), 0);
    @(negedge clk_in);
    check_i({name, " done_width"}, int'(frame_done), 0);
  endtask

  initial begin
    rst_in = 1; frame_start = 0; tri_count = '0; hang = 0; rnd_ready = 0;
    stall_beat = -1; stall_len = 0; stall_cnt = 0;
    n_vec = 0; n_err = 0; starts = 0; beats = 0;
    repeat (3) @(negedge clk_in);
    check_i("rst frame_busy", int'(frame_busy), 0);
    check_i("rst out_valid", int'(out_valid), 0);
    check_i("rst proj_start", int'(proj_start), 0);
    check_i("rst mem_addr", int'(mem_addr), 0);
    check_i("rst counts", int'(emitted_count) + int'(culled_count), 0);
    rst_in = 0;
    @(negedge clk_in);

    start_frame(3, 0);
    end_frame("t1", 3, 0, 3);

    fixed_codes = '{0, 1, 2, 0};
    start_frame(4, 1);
    end_frame("t2", 2, 2, 4);

    start_frame(0, 0);
    check_i("t3 done early", int'(frame_done), 0);
    @(negedge clk_in);
    check_i("t3 done at 2", int'(frame_done), 1);
    check_i("t3 starts", starts - starts0, 0);
    check_i("t3 emitted", int'(emitted_count), 0);

    stall_beat = 1; stall_len = 50; stall_cnt = 0;
    start_frame(3, 0);
    end_frame("t4", 3, 0, 3);
    check_i("t4 stall cycles", stall_cnt, 50);
    stall_beat = -1;

    start_frame(5, 2);
    repeat (6) @(negedge clk_in);
    tri_count = AW'(9); frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
    end_frame("t5", mdl_e, mdl_c, 5);

    start_frame(3, 0);
    repeat (19) @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    check_i("t6 busy", int'(frame_busy), 0);
    check_i("t6 out_valid", int'(out_valid), 0);
    check_i("t6 proj_start", int'(proj_start), 0);
    check_i("t6 counts", int'(emitted_count) + int'(culled_count) + int'(mem_addr), 0);
    check_v("t6 out_verts", out_verts, '0);
    check_v("t6 proj_verts", proj_verts, '0);
    @(negedge clk_in);
    rst_in = 0; exp_q.delete();
    @(negedge clk_in);
    start_frame(3, 0);
    end_frame("t6b", 3, 0, 3);

    rnd_ready = 1;
    for (int f = 0; f < 8; f++) begin
      start_frame($urandom_range(1, 12), 2);
      end_frame("rand", mdl_e, mdl_c, starts0 >= 0 ? mdl_e + mdl_c : 0);
    end
    rnd_ready = 0;

`ifdef TRI_SCHED_WATCHDOG_EN
    hang = 1;
    for (int w = 0; w < 9; w++) mem[0][w*CW +: CW] = $urandom;
    mem[0][1:0] = 2'd0;
    starts0 = starts; tri_count = AW'(1); frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
    end_frame("wdog", 0, 1, 1);
    check_i("wdog flag", int'(wdog_flag), 1);
    rst_in = 1; hang = 0;
    repeat (2) @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in);
    check_i("wdog flag after rst", int'(wdog_flag), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
